// File: rtl/key_ctrl_pkg.sv
// Shared definitions for the player-input controller: width helper,
// default timing constants, and the event-index width derivation.
package key_ctrl_pkg;

   // Default timing constants (cycles at the board clock)
   localparam int unsigned DEF_N_KEYS          = 32'd4;
   localparam int unsigned DEF_DEBOUNCE_CYCLES = 32'd250000;
   localparam int unsigned DEF_REPEAT_DELAY    = 32'd12500000;
   localparam int unsigned DEF_REPEAT_PERIOD   = 32'd2500000;

   // Bits needed to hold values 0..n-1, never less than one bit
   function automatic int unsigned clog2_min1(input int unsigned n);
      int unsigned w;
      w = 32'd0;
      for (int i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(n)) begin
            w = 32'(i + 1);
         end else begin
            w = w;
         end
      end
      if (w == 32'd0) begin
         w = 32'd1;
      end else begin
         w = w;
      end
      return w;
   endfunction

   // Width of the presented key index for a given key count
   function automatic int unsigned key_width(input int unsigned n_keys);
      return clog2_min1(n_keys);
   endfunction

endpackage

// File: rtl/key_debounce.sv
// One button lane: two-flop synchronizer, debounce counter and press strobe.
// With KEY_AUTO_REPEAT_EN defined, a repeat counter re-strobes `press`
// while the key stays held.
module key_debounce
   import key_ctrl_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic clk,
   input  logic rst,
   input  logic key_in,
   output logic key_level,
   output logic press
);

   localparam int unsigned   CW       = clog2_min1(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 32'd1);

   logic          sync1_r;
   logic          sync2_r;
   logic          level_r;
   logic [CW-1:0] cnt_r;
   logic          flip_s;
   logic          rise_s;

   // Bring the asynchronous button into the clock domain
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
      end else begin
         sync1_r <= key_in;
         sync2_r <= sync1_r;
      end
   end

   // Accept a level change once the input has disagreed for the whole window
   always_comb begin
      flip_s = 1'b0;
      rise_s = 1'b0;
      if ((sync2_r != level_r) && (cnt_r == CNT_LAST)) begin
         flip_s = 1'b1;
         rise_s = ~level_r;
      end else begin
         flip_s = 1'b0;
         rise_s = 1'b0;
      end
   end

   // Debounce counter and accepted level
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r   <= '0;
         level_r <= 1'b0;
      end else if (sync2_r == level_r) begin
         cnt_r   <= '0;
         level_r <= level_r;
      end else if (flip_s) begin
         cnt_r   <= '0;
         level_r <= sync2_r;
      end else begin
         cnt_r   <= cnt_r + CW'(1);
         level_r <= level_r;
      end
   end

`ifdef KEY_AUTO_REPEAT_EN
   localparam int unsigned   RW = clog2_min1((REPEAT_DELAY > REPEAT_PERIOD) ?
                                             REPEAT_DELAY : REPEAT_PERIOD);
   localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 32'd1);
   localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 32'd1);

   logic [RW-1:0] rpt_r;
   logic          periodic_r;
   logic          rpt_fire_s;

   // A repeat is due when the held time reaches the current interval
   always_comb begin
      rpt_fire_s = 1'b0;
      if (!level_r) begin
         rpt_fire_s = 1'b0;
      end else if (periodic_r) begin
         rpt_fire_s = (rpt_r == PERIOD_LAST);
      end else begin
         rpt_fire_s = (rpt_r == DELAY_LAST);
      end
   end

   // Held-time counter; first interval is the delay, then the period
   always_ff @(posedge clk) begin
      if (rst || !level_r) begin
         rpt_r      <= '0;
         periodic_r <= 1'b0;
      end else if (rpt_fire_s) begin
         rpt_r      <= '0;
         periodic_r <= 1'b1;
      end else begin
         rpt_r      <= rpt_r + RW'(1);
         periodic_r <= periodic_r;
      end
   end

   assign press = rise_s | rpt_fire_s;
`else
   logic [31:0] repeat_cfg_unused_s;
   assign repeat_cfg_unused_s = REPEAT_DELAY ^ REPEAT_PERIOD;
   assign press = rise_s;
`endif

   assign key_level = level_r;

endmodule

// File: rtl/key_ctrl.sv
// Player-input controller top: one debounce lane per button, per-key pending
// flags, a fixed-priority pick (index 0 first) and a valid/ready event register.
// Optional feature macro: KEY_AUTO_REPEAT_EN (auto-repeat while a key is held).
module key_ctrl
   import key_ctrl_pkg::*;
#(
   parameter int unsigned  N_KEYS          = DEF_N_KEYS,
   parameter int unsigned  DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned  REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int unsigned  REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
   localparam int unsigned KW              = key_width(N_KEYS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_KEYS-1:0] key_in,
   output logic [N_KEYS-1:0] key_level,
   output logic              evt_valid,
   output logic [KW-1:0]     evt_key,
   input  logic              evt_ready
);

   logic [N_KEYS-1:0] press_s;
   logic [N_KEYS-1:0] pend_r;
   logic [N_KEYS-1:0] clr_s;
   logic [KW-1:0]     pick_s;
   logic              any_pend_s;
   logic              free_s;
   logic              evt_valid_r;
   logic [KW-1:0]     evt_key_r;

   for (genvar g = 0; g < N_KEYS; g++) begin : g_lane
      key_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD)
      ) u_lane (
         .clk       (clk),
         .rst       (rst),
         .key_in    (key_in[g]),
         .key_level (key_level[g]),
         .press     (press_s[g])
      );
   end

   // Pick the lowest pending index and decide whether it is taken this edge
   always_comb begin
      pick_s     = '0;
      clr_s      = '0;
      any_pend_s = (pend_r != '0);
      free_s     = ~evt_valid_r | evt_ready;
      for (int i = int'(N_KEYS) - 1; i >= 0; i--) begin
         if (pend_r[i]) begin
            pick_s = KW'(i);
         end else begin
            pick_s = pick_s;
         end
      end
      if (free_s && any_pend_s) begin
         clr_s[pick_s] = 1'b1;
      end else begin
         clr_s = '0;
      end
   end

   // Pending flags; a new press on the same edge as the take keeps the flag
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_r <= '0;
      end else begin
         pend_r <= (pend_r & ~clr_s) | press_s;
      end
   end

   // Event output register, held stable while the consumer stalls
   always_ff @(posedge clk) begin
      if (rst) begin
         evt_valid_r <= 1'b0;
         evt_key_r   <= '0;
      end else if (free_s && any_pend_s) begin
         evt_valid_r <= 1'b1;
         evt_key_r   <= pick_s;
      end else if (free_s) begin
         evt_valid_r <= 1'b0;
         evt_key_r   <= evt_key_r;
      end else begin
         evt_valid_r <= evt_valid_r;
         evt_key_r   <= evt_key_r;
      end
   end

   assign evt_valid = evt_valid_r;
   assign evt_key   = evt_key_r;

endmodule

// File: tb/tb_key_ctrl.sv
// Self-checking bench for key_ctrl with short timing parameters.
module tb_key_ctrl;

   localparam int N  = 4;
   localparam int D  = 4;
   localparam int RD = 20;
   localparam int RP = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [3:0]   key_in = 4'd0;
   logic         evt_ready = 1'b1;
   logic [3:0]   key_level;
   logic         evt_valid;
   logic [1:0]   evt_key;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   key_ctrl #(
      .N_KEYS          (N),
      .DEBOUNCE_CYCLES (D),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .key_in    (key_in),
      .key_level (key_level),
      .evt_valid (evt_valid),
      .evt_key   (evt_key),
      .evt_ready (evt_ready)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Behavioural model: keys become accepted after D straight disagreeing
   // samples of the 2-cycle-delayed input; presses/repeats raise a pending set;
   // a free output takes the lowest pending key.
   bit       m_on = 1'b0;
   bit [3:0] m_s1, m_s2, m_lvl, m_pend;
   int       m_run [4];
   int       m_held [4];
   bit       m_v;
   bit [1:0] m_k;

   initial begin
      forever begin : step
         bit [3:0] prs;
         bit [3:0] nl;
         bit [3:0] clr;
         int       j;
         @(posedge clk);
         if (rst) begin
            m_s1 = 4'd0; m_s2 = 4'd0; m_lvl = 4'd0; m_pend = 4'd0;
            m_v = 1'b0; m_k = 2'd0;
            for (int i = 0; i < N; i++) begin
               m_run[i] = 0;
               m_held[i] = 0;
            end
            m_on = 1'b1;
         end else begin
            prs = 4'd0; nl = m_lvl; clr = 4'd0;
            for (int i = 0; i < N; i++) begin
               if (m_s2[i] != m_lvl[i]) begin
                  m_run[i]++;
                  if (m_run[i] == D) begin
                     nl[i] = m_s2[i];
                     m_run[i] = 0;
                     prs[i] = m_s2[i];
                  end
               end else begin
                  m_run[i] = 0;
               end
`ifdef KEY_AUTO_REPEAT_EN
               if (m_lvl[i]) begin
                  m_held[i]++;
                  if (m_held[i] == RD || (m_held[i] > RD && (m_held[i] - RD) % RP == 0))
                     prs[i] = 1'b1;
               end else begin
                  m_held[i] = 0;
               end
`endif
            end
            if (!m_v || evt_ready) begin
               if (m_pend != 4'd0) begin
                  j = 0;
                  while (!m_pend[j]) j++;
                  m_k = j[1:0];
                  m_v = 1'b1;
                  clr[j] = 1'b1;
               end else begin
                  m_v = 1'b0;
               end
            end
            m_pend = (m_pend & ~clr) | prs;
            m_lvl  = nl;
            m_s2   = m_s1;
            m_s1   = key_in;
         end
      end
   end

   // Every-cycle comparison against the model
   initial begin
      forever begin
         @(negedge clk);
         if (m_on) begin
            chk("model_key_level", 32'(key_level), 32'(m_lvl));
            chk("model_evt_valid", 32'(evt_valid), 32'(m_v));
            chk("model_evt_key",   32'(evt_key),   32'(m_k));
         end
      end
   end

   // Directed stimulus with hand-computed expectations
   initial begin
      int cnt;
      rst = 1'b1; key_in = 4'd0; evt_ready = 1'b1;
      tick(3);
      rst = 1'b0;
      tick(2);
      chk("reset_level", 32'(key_level), 32'd0);
      chk("reset_valid", 32'(evt_valid), 32'd0);
      chk("reset_key",   32'(evt_key),   32'd0);

      // single press on key 2
      key_in[2] = 1'b1;
      tick(5);
      chk("press_level_e4", 32'(key_level[2]), 32'd0);
      tick(1);
      chk("press_level_e5", 32'(key_level[2]), 32'd1);
      chk("press_valid_e5", 32'(evt_valid), 32'd0);
      tick(1);
      chk("press_valid_e6", 32'(evt_valid), 32'd1);
      chk("press_key_e6",   32'(evt_key),   32'd2);
      tick(1);
      chk("press_valid_e7", 32'(evt_valid), 32'd0);
      key_in[2] = 1'b0;
      tick(10);

      // 3-cycle glitch on key 1
      key_in[1] = 1'b1;
      tick(3);
      key_in[1] = 1'b0;
      tick(12);
      chk("glitch_level", 32'(key_level), 32'd0);
      chk("glitch_valid", 32'(evt_valid), 32'd0);

      // simultaneous keys 0 and 3
      key_in = 4'b1001;
      tick(6);
      chk("simul_level", 32'(key_level), 32'h9);
      tick(1);
      chk("simul_valid_a", 32'(evt_valid), 32'd1);
      chk("simul_key_a",   32'(evt_key),   32'd0);
      tick(1);
      chk("simul_valid_b", 32'(evt_valid), 32'd1);
      chk("simul_key_b",   32'(evt_key),   32'd3);
      tick(1);
      chk("simul_valid_c", 32'(evt_valid), 32'd0);
      key_in = 4'd0;
      tick(10);

      // backpressure with a re-press of key 1
      evt_ready = 1'b0;
      key_in[1] = 1'b1;
      tick(7);
      chk("bp_valid_a", 32'(evt_valid), 32'd1);
      chk("bp_key_a",   32'(evt_key),   32'd1);
      key_in[1] = 1'b0;
      tick(10);
      chk("bp_level_low", 32'(key_level[1]), 32'd0);
      chk("bp_key_b",     32'(evt_key),      32'd1);
      key_in[1] = 1'b1;
      tick(10);
      chk("bp_valid_c", 32'(evt_valid), 32'd1);
      chk("bp_key_c",   32'(evt_key),   32'd1);
      evt_ready = 1'b1;
      tick(1);
      chk("bp_valid_d", 32'(evt_valid), 32'd1);
      chk("bp_key_d",   32'(evt_key),   32'd1);
      tick(1);
      chk("bp_valid_e", 32'(evt_valid), 32'd0);
      key_in[1] = 1'b0;
      tick(10);

      // reset while an event is presented and key 2 is held
      evt_ready = 1'b0;
      key_in[2] = 1'b1;
      tick(7);
      chk("rst_pre_valid", 32'(evt_valid), 32'd1);
      rst = 1'b1;
      tick(1);
      chk("rst_valid", 32'(evt_valid), 32'd0);
      chk("rst_key",   32'(evt_key),   32'd0);
      chk("rst_level", 32'(key_level), 32'd0);
      tick(1);
      rst = 1'b0;
      tick(6);
      chk("rst_post_e5_valid", 32'(evt_valid), 32'd0);
      chk("rst_post_e5_level", 32'(key_level[2]), 32'd1);
      tick(1);
      chk("rst_post_e6_valid", 32'(evt_valid), 32'd1);
      chk("rst_post_e6_key",   32'(evt_key),   32'd2);
      evt_ready = 1'b1;
      tick(1);
      chk("rst_post_e7_valid", 32'(evt_valid), 32'd0);
      key_in[2] = 1'b0;
      tick(10);

      // long hold on key 0: count presented events
      cnt = 0;
      key_in[0] = 1'b1;
      for (int t = 0; t < 55; t++) begin
         tick(1);
         if (evt_valid) cnt++;
      end
      key_in[0] = 1'b0;
      for (int t = 0; t < 15; t++) begin
         tick(1);
         if (evt_valid) cnt++;
      end
`ifdef KEY_AUTO_REPEAT_EN
      chk("hold_event_count", 32'(cnt), 32'd6);
`else
      chk("hold_event_count", 32'(cnt), 32'd1);
`endif
      tick(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
